// File: rtl/frame_ctrl_pkg.sv
// Shared types and pixel-coordinate widths for the frame cursor controller.
package frame_ctrl_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef enum logic [1:0] {
        NAVIGATE    = 2'd0,
        SELECT_PEND = 2'd1,
        SELECTED    = 2'd2
    } state_t;

endpackage

// File: rtl/frame_blink_timer.sv
// Counts frame ticks while enabled; pulses toggle on every BLINK_HALF-th tick.
module frame_blink_timer #(
    parameter int BLINK_HALF = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic toggle
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] count;

    assign toggle = enable & tick & ~clear & (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && tick) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/frame_cursor_ctrl.sv
// Grid-selection cursor for the frame sprite: pending moves, frame-aligned
// commits, select/deselect sequencing and blink while selected.
module frame_cursor_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int                    GRID_COLS  = 8,
    parameter int                    GRID_ROWS  = 6,
    parameter logic [HCOUNT_W-1:0]   CELL_W     = 11'd64,
    parameter logic [VCOUNT_W-1:0]   CELL_H     = 10'd64,
    parameter logic [HCOUNT_W-1:0]   X0         = 11'd128,
    parameter logic [VCOUNT_W-1:0]   Y0         = 10'd104,
    parameter bit                    WRAP       = 1'b0,
    parameter int                    BLINK_HALF = 15,
    localparam int                   CW         = $clog2(GRID_COLS),
    localparam int                   RW         = $clog2(GRID_ROWS)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                new_frame_in,
    input  logic                up_in,
    input  logic                down_in,
    input  logic                left_in,
    input  logic                right_in,
    input  logic                select_in,
    output logic [HCOUNT_W-1:0] x_out,
    output logic [VCOUNT_W-1:0] y_out,
    output logic [HCOUNT_W-1:0] width_out,
    output logic [VCOUNT_W-1:0] height_out,
    output logic                visible_out,
    output logic [CW-1:0]       col_out,
    output logic [RW-1:0]       row_out,
    output logic                selected_out,
    output logic                select_pulse_out
);

    localparam logic [CW-1:0]       COL_LAST = CW'(GRID_COLS - 1);
    localparam logic [RW-1:0]       ROW_LAST = RW'(GRID_ROWS - 1);
    localparam logic [HCOUNT_W-1:0] X_LAST   = X0 + HCOUNT_W'(GRID_COLS - 1) * CELL_W;
    localparam logic [VCOUNT_W-1:0] Y_LAST   = Y0 + VCOUNT_W'(GRID_ROWS - 1) * CELL_H;

    state_t state, state_nxt;

    logic [CW-1:0]       pcol, pcol_nxt;
    logic [RW-1:0]       prow, prow_nxt;
    logic [HCOUNT_W-1:0] px, px_nxt;
    logic [VCOUNT_W-1:0] py, py_nxt;
    logic                desel_pend;
    logic                enter_sel;
    logic                leave_sel;
    logic                blink_toggle;
    logic                go_r, go_l, go_u, go_d;

    assign width_out  = CELL_W;
    assign height_out = CELL_H;

    assign enter_sel = (state == SELECT_PEND) & ~select_in & new_frame_in;
    assign leave_sel = (state == SELECTED) & desel_pend & new_frame_in;

    // Opposing pulses in the same cycle cancel each other out.
    assign go_r = right_in & ~left_in;
    assign go_l = left_in & ~right_in;
    assign go_d = down_in & ~up_in;
    assign go_u = up_in & ~down_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= NAVIGATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            NAVIGATE:    if (select_in) state_nxt = SELECT_PEND;
            SELECT_PEND: begin
                if (select_in)         state_nxt = NAVIGATE;
                else if (new_frame_in) state_nxt = SELECTED;
            end
            SELECTED:    if (leave_sel) state_nxt = NAVIGATE;
            default:     state_nxt = NAVIGATE;
        endcase
    end

    // Pixel coordinates follow the cell index by add/subtract only.
    always_comb begin
        pcol_nxt = pcol;
        px_nxt   = px;
        prow_nxt = prow;
        py_nxt   = py;
        if (state == NAVIGATE) begin
            if (go_r) begin
                if (pcol != COL_LAST) begin
                    pcol_nxt = pcol + CW'(1);
                    px_nxt   = px + CELL_W;
                end else if (WRAP) begin
                    pcol_nxt = '0;
                    px_nxt   = X0;
                end
            end else if (go_l) begin
                if (pcol != '0) begin
                    pcol_nxt = pcol - CW'(1);
                    px_nxt   = px - CELL_W;
                end else if (WRAP) begin
                    pcol_nxt = COL_LAST;
                    px_nxt   = X_LAST;
                end
            end
            if (go_d) begin
                if (prow != ROW_LAST) begin
                    prow_nxt = prow + RW'(1);
                    py_nxt   = py + CELL_H;
                end else if (WRAP) begin
                    prow_nxt = '0;
                    py_nxt   = Y0;
                end
            end else if (go_u) begin
                if (prow != '0) begin
                    prow_nxt = prow - RW'(1);
                    py_nxt   = py - CELL_H;
                end else if (WRAP) begin
                    prow_nxt = ROW_LAST;
                    py_nxt   = Y_LAST;
                end
            end
        end
    end

    frame_blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk    (clk_in),
        .rst    (rst_in),
        .tick   (new_frame_in),
        .enable (state == SELECTED),
        .clear  (enter_sel),
        .toggle (blink_toggle)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pcol             <= '0;
            prow             <= '0;
            px               <= X0;
            py               <= Y0;
            col_out          <= '0;
            row_out          <= '0;
            x_out            <= X0;
            y_out            <= Y0;
            visible_out      <= 1'b1;
            selected_out     <= 1'b0;
            select_pulse_out <= 1'b0;
            desel_pend       <= 1'b0;
        end else begin
            pcol             <= pcol_nxt;
            prow             <= prow_nxt;
            px               <= px_nxt;
            py               <= py_nxt;
            selected_out     <= (state_nxt == SELECTED);
            select_pulse_out <= enter_sel;
            // Commit takes the pending values from before this cycle's moves.
            if (new_frame_in) begin
                col_out <= pcol;
                row_out <= prow;
                x_out   <= px;
                y_out   <= py;
            end
            if (enter_sel || leave_sel) visible_out <= 1'b1;
            else if (blink_toggle)      visible_out <= ~visible_out;
            if (leave_sel)
                desel_pend <= 1'b0;
            else if (state == SELECTED && select_in)
                desel_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_cursor_ctrl.sv
// Randomized and directed checks of frame_cursor_ctrl (clamp and wrap builds)
// against a cell-index reference model.
module tb_frame_cursor_ctrl;

    logic clk = 1'b0;
    logic rst, nf, up, dn, lf, rt, sel;

    logic [10:0] x_o [2];
    logic [9:0]  y_o [2];
    logic [10:0] w_o [2];
    logic [9:0]  h_o [2];
    logic        vis_o [2];
    logic [2:0]  col_o [2];
    logic [2:0]  row_o [2];
    logic        sel_o [2];
    logic        pul_o [2];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, index 0 = clamp build, 1 = wrap build.
    // md: 0 navigate, 1 waiting for frame to select, 2 selected.
    int pc [2], pr [2], cc [2], cr [2], md [2];
    int blk [2], vis [2], pul [2], des [2];

    always #5 clk = ~clk;

    frame_cursor_ctrl #(.WRAP(1'b0)) u_clamp (
        .clk_in(clk), .rst_in(rst), .new_frame_in(nf),
        .up_in(up), .down_in(dn), .left_in(lf), .right_in(rt),
        .select_in(sel),
        .x_out(x_o[0]), .y_out(y_o[0]), .width_out(w_o[0]),
        .height_out(h_o[0]), .visible_out(vis_o[0]),
        .col_out(col_o[0]), .row_out(row_o[0]),
        .selected_out(sel_o[0]), .select_pulse_out(pul_o[0])
    );

    frame_cursor_ctrl #(.WRAP(1'b1)) u_wrap (
        .clk_in(clk), .rst_in(rst), .new_frame_in(nf),
        .up_in(up), .down_in(dn), .left_in(lf), .right_in(rt),
        .select_in(sel),
        .x_out(x_o[1]), .y_out(y_o[1]), .width_out(w_o[1]),
        .height_out(h_o[1]), .visible_out(vis_o[1]),
        .col_out(col_o[1]), .row_out(row_o[1]),
        .selected_out(sel_o[1]), .select_pulse_out(pul_o[1])
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int move(input int v, input int d, input int n, input int w);
        int r;
        r = v + d;
        if (w != 0) r = (r + n) % n;
        else if (r < 0) r = 0;
        else if (r > n - 1) r = n - 1;
        return r;
    endfunction

    task automatic model_step(input int w);
        if (rst) begin
            pc[w] = 0; pr[w] = 0; cc[w] = 0; cr[w] = 0; md[w] = 0;
            blk[w] = 0; vis[w] = 1; pul[w] = 0; des[w] = 0;
            return;
        end
        pul[w] = 0;
        if (nf) begin
            cc[w] = pc[w];
            cr[w] = pr[w];
        end
        case (md[w])
            0: begin
                pc[w] = move(pc[w], int'(rt) - int'(lf), 8, w);
                pr[w] = move(pr[w], int'(dn) - int'(up), 6, w);
                if (sel) md[w] = 1;
            end
            1: begin
                if (sel) md[w] = 0;
                else if (nf) begin
                    md[w] = 2; pul[w] = 1; blk[w] = 0; vis[w] = 1;
                end
            end
            default: begin
                if (nf && des[w] != 0) begin
                    md[w] = 0; vis[w] = 1; des[w] = 0;
                end else begin
                    if (nf) begin
                        blk[w]++;
                        if (blk[w] == 15) begin
                            blk[w] = 0;
                            vis[w] = 1 - vis[w];
                        end
                    end
                    if (sel) des[w] = 1;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        for (int w = 0; w < 2; w++) begin
            check($sformatf("x%0d", w), int'(x_o[w]), 128 + cc[w] * 64);
            check($sformatf("y%0d", w), int'(y_o[w]), 104 + cr[w] * 64);
            check($sformatf("width%0d", w), int'(w_o[w]), 64);
            check($sformatf("height%0d", w), int'(h_o[w]), 64);
            check($sformatf("col%0d", w), int'(col_o[w]), cc[w]);
            check($sformatf("row%0d", w), int'(row_o[w]), cr[w]);
            check($sformatf("visible%0d", w), int'(vis_o[w]), vis[w]);
            check($sformatf("selected%0d", w), int'(sel_o[w]), int'(md[w] == 2));
            check($sformatf("pulse%0d", w), int'(pul_o[w]), pul[w]);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic u,
                        input logic d, input logic l, input logic ri,
                        input logic s);
        rst = r; nf = f; up = u; dn = d; lf = l; rt = ri; sel = s;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        step(0, 1, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        rst = 1; nf = 0; up = 0; dn = 0; lf = 0; rt = 0; sel = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_x", int'(x_o[0]), 128);
        check("rst_vis", int'(vis_o[0]), 1);

        // Three rights: no change until the frame commit.
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        idle();
        check("precommit_col", int'(col_o[0]), 0);
        frame();
        check("r3_x", int'(x_o[0]), 320);
        check("r3_col", int'(col_o[0]), 3);
        check("r3_y", int'(y_o[0]), 104);

        // Left edge: clamp vs wrap.
        repeat (3) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        frame();
        check("clamp_col", int'(col_o[0]), 0);
        check("clamp_x", int'(x_o[0]), 128);
        check("wrap_col", int'(col_o[1]), 7);
        check("wrap_x", int'(x_o[1]), 576);

        // Up+down cancel while right still applies.
        step(0, 0, 1, 1, 0, 1, 0);
        frame();
        check("ud_row", int'(row_o[0]), 0);
        check("ud_col", int'(col_o[0]), 1);

        // Move coincident with the frame pulse lands a frame later.
        step(0, 1, 0, 1, 0, 0, 0);
        idle();
        check("defer_row", int'(row_o[0]), 0);
        frame();
        check("defer_row2", int'(row_o[0]), 1);

        // Select, blink, then reset while hidden.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("sel_pulse", int'(pul_o[0]), 1);
        idle();
        check("sel_pulse_end", int'(pul_o[0]), 0);
        step(0, 0, 0, 0, 0, 1, 0);
        repeat (15) frame();
        check("blink15", int'(vis_o[0]), 0);
        check("sel_frozen_col", int'(col_o[0]), 1);
        repeat (15) frame();
        check("blink30", int'(vis_o[0]), 1);
        repeat (15) frame();
        check("blink45", int'(vis_o[0]), 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_sel", int'(sel_o[0]), 0);
        check("rst_vis2", int'(vis_o[0]), 1);

        // Select, hide, deselect: visible forced on.
        step(0, 0, 0, 0, 0, 0, 1);
        frame();
        repeat (15) frame();
        step(0, 0, 0, 0, 0, 0, 1);
        frame();
        check("desel_vis", int'(vis_o[0]), 1);
        check("desel_sel", int'(sel_o[0]), 0);

        // Select then cancel before the frame.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("cancel_pulse", int'(pul_o[0]), 0);
        check("cancel_sel", int'(sel_o[0]), 0);

        for (int i = 0; i < 6000; i++) begin
            logic r, f, s;
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 24) == 0) && !f;
            step(r, f, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
